// File: rtl/unidade_controle_if.sv
// unidade_controle_if
//    Bundle of every signal exchanged between the multicycle control unit and
//    the 8-bit datapath/memory side.
//    master : the control unit (drives strobes, selects, status; reads IR,
//             ALU zero flag and memory-ready)
//    slave  : the datapath/memory side (the mirror image)
//    Signals:
//       instrucao[7:0]   IR contents, opcode in [7:4]
//       zero             ALU zero flag
//       mem_pronto       memory access completes this cycle
//       sinal_ula[2:0]   ALU operation
//       origem_ula_a/b   ALU operand selects
//       origem_pc[1:0]   PC source select
//       iord             memory address select (0 PC, 1 address register)
//       le_mem/escreve_mem, escreve_ir/pc/end/reg, mem_para_reg
//       parado, erro[1:0], contador_instrucoes[LARGURA_CONT-1:0]
interface unidade_controle_if #(
   parameter int LARGURA_CONT = 16
);
   logic [7:0]              instrucao;
   logic                    zero;
   logic                    mem_pronto;
   logic [2:0]              sinal_ula;
   logic                    origem_ula_a;
   logic [1:0]              origem_ula_b;
   logic [1:0]              origem_pc;
   logic                    iord;
   logic                    le_mem;
   logic                    escreve_mem;
   logic                    escreve_ir;
   logic                    escreve_pc;
   logic                    escreve_end;
   logic                    escreve_reg;
   logic                    mem_para_reg;
   logic                    parado;
   logic [1:0]              erro;
   logic [LARGURA_CONT-1:0] contador_instrucoes;

   modport master (
      input  instrucao, zero, mem_pronto,
      output sinal_ula, origem_ula_a, origem_ula_b, origem_pc, iord,
             le_mem, escreve_mem, escreve_ir, escreve_pc, escreve_end,
             escreve_reg, mem_para_reg, parado, erro, contador_instrucoes
   );

   modport slave (
      output instrucao, zero, mem_pronto,
      input  sinal_ula, origem_ula_a, origem_ula_b, origem_pc, iord,
             le_mem, escreve_mem, escreve_ir, escreve_pc, escreve_end,
             escreve_reg, mem_para_reg, parado, erro, contador_instrucoes
   );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle
//    Multicycle control FSM of the 8-bit processor. Sequences fetch, decode,
//    execute, memory access and writeback; drives the datapath write strobes
//    and mux selects, produces the ALU operation and consumes its zero flag.
//    Halts on HALT or when memory does not answer within LIMITE_ESPERA cycles.
//    Ports:
//       clock  rising-edge system clock
//       reset  synchronous, active-high; forces all strobes/selects to 0
//       bus    unidade_controle_if.master (datapath/memory handshake)
//    Strobes and selects are combinational from state, opcode, zero and
//    mem_pronto; erro and contador_instrucoes are registered.
module unidade_controle #(
   parameter int LIMITE_ESPERA = 15,
   parameter int LARGURA_CONT  = 16
) (
   input  logic              clock,
   input  logic              reset,
   unidade_controle_if.master bus
);

   localparam int LARG_ESPERA = $clog2(LIMITE_ESPERA + 1);

   localparam logic [2:0] ULA_ADD = 3'b010;
   localparam logic [2:0] ULA_SUB = 3'b011;

   localparam logic [3:0] OP_ADDI = 4'b0101;
   localparam logic [3:0] OP_LW   = 4'b0110;
   localparam logic [3:0] OP_SW   = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_JMP  = 4'b1001;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [3:0] {
      BUSCA,
      DECODIFICA,
      EXEC_R,
      EXEC_I,
      CALC_END,
      ACESSO_MEM,
      ESCRITA_REG,
      DESVIO,
      SALTO,
      PARADO
   } estado_t;

   estado_t                 estado;
   estado_t                 prox;
   logic [LARG_ESPERA-1:0]  espera;
   logic [1:0]              erro_q;
   logic [LARGURA_CONT-1:0] cont_q;

   logic [3:0] opcode;
   logic       em_espera;
   logic       estouro;
   logic       retira;
   logic       ilegal;

   logic [2:0] sinal_ula;
   logic       origem_ula_a;
   logic [1:0] origem_ula_b;
   logic [1:0] origem_pc;
   logic       iord;
   logic       le_mem;
   logic       escreve_mem;
   logic       escreve_ir;
   logic       escreve_pc;
   logic       escreve_end;
   logic       escreve_reg;
   logic       mem_para_reg;
   logic       parado;

   assign opcode    = bus.instrucao[7:4];
   assign em_espera = (estado == BUSCA) || (estado == ACESSO_MEM);
   // espera counts the cycles already spent waiting, so the cycle where it
   // holds LIMITE_ESPERA-1 is the last one allowed; mem_pronto there still wins.
   assign estouro   = em_espera && !bus.mem_pronto &&
                      (espera == LARG_ESPERA'(LIMITE_ESPERA - 1));

   always_comb begin
      prox         = estado;
      retira       = 1'b0;
      ilegal       = 1'b0;
      sinal_ula    = 3'b000;
      origem_ula_a = 1'b0;
      origem_ula_b = 2'b00;
      origem_pc    = 2'b00;
      iord         = 1'b0;
      le_mem       = 1'b0;
      escreve_mem  = 1'b0;
      escreve_ir   = 1'b0;
      escreve_pc   = 1'b0;
      escreve_end  = 1'b0;
      escreve_reg  = 1'b0;
      mem_para_reg = 1'b0;
      parado       = 1'b0;

      case (estado)
         BUSCA: begin
            le_mem = 1'b1;
            if (bus.mem_pronto) begin
               // IR load and PC+1 happen together on the completing cycle
               escreve_ir   = 1'b1;
               escreve_pc   = 1'b1;
               origem_ula_b = 2'b01;
               sinal_ula    = ULA_ADD;
               prox         = DECODIFICA;
            end
         end
         DECODIFICA: begin
            if (opcode <= 4'd4)                           prox = EXEC_R;
            else if (opcode == OP_ADDI)                   prox = EXEC_I;
            else if (opcode == OP_LW || opcode == OP_SW)  prox = CALC_END;
            else if (opcode == OP_BEQ)                    prox = DESVIO;
            else if (opcode == OP_JMP)                    prox = SALTO;
            else if (opcode == OP_HALT)                   prox = PARADO;
            else begin
               ilegal = 1'b1;
               prox   = BUSCA;
            end
         end
         EXEC_R: begin
            origem_ula_a = 1'b1;
            sinal_ula    = opcode[2:0];
            prox         = ESCRITA_REG;
         end
         EXEC_I: begin
            origem_ula_a = 1'b1;
            origem_ula_b = 2'b10;
            sinal_ula    = ULA_ADD;
            prox         = ESCRITA_REG;
         end
         CALC_END: begin
            origem_ula_a = 1'b1;
            origem_ula_b = 2'b10;
            sinal_ula    = ULA_ADD;
            escreve_end  = 1'b1;
            prox         = ACESSO_MEM;
         end
         ACESSO_MEM: begin
            iord        = 1'b1;
            le_mem      = (opcode == OP_LW);
            escreve_mem = (opcode == OP_SW);
            if (bus.mem_pronto) begin
               if (opcode == OP_LW) begin
                  prox = ESCRITA_REG;
               end else begin
                  prox   = BUSCA;
                  retira = 1'b1;
               end
            end
         end
         ESCRITA_REG: begin
            escreve_reg  = 1'b1;
            mem_para_reg = (opcode == OP_LW);
            prox         = BUSCA;
            retira       = 1'b1;
         end
         DESVIO: begin
            origem_ula_a = 1'b1;
            sinal_ula    = ULA_SUB;
            origem_pc    = 2'b01;
            escreve_pc   = bus.zero;
            prox         = BUSCA;
            retira       = 1'b1;
         end
         SALTO: begin
            escreve_pc = 1'b1;
            origem_pc  = 2'b10;
            prox       = BUSCA;
            retira     = 1'b1;
         end
         PARADO: begin
            parado = 1'b1;
         end
         default: begin
            prox = BUSCA;
         end
      endcase

      if (estouro) begin
         prox = PARADO;
      end

      // A request in flight drops on the very cycle reset is asserted.
      if (reset) begin
         sinal_ula    = 3'b000;
         origem_ula_a = 1'b0;
         origem_ula_b = 2'b00;
         origem_pc    = 2'b00;
         iord         = 1'b0;
         le_mem       = 1'b0;
         escreve_mem  = 1'b0;
         escreve_ir   = 1'b0;
         escreve_pc   = 1'b0;
         escreve_end  = 1'b0;
         escreve_reg  = 1'b0;
         mem_para_reg = 1'b0;
         parado       = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= BUSCA;
         espera <= '0;
         erro_q <= 2'b00;
         cont_q <= '0;
      end else begin
         estado <= prox;
         // Staying in a wait state means memory has not answered yet; any
         // transition (including re-entry from elsewhere) restarts the count.
         if (em_espera && (prox == estado)) begin
            espera <= espera + 1'b1;
         end else begin
            espera <= '0;
         end
         if (ilegal) begin
            erro_q <= 2'b01;
         end
         if (estouro) begin
            erro_q <= 2'b10;
         end
         if (retira) begin
            cont_q <= cont_q + 1'b1;
         end
      end
   end

   assign bus.sinal_ula           = sinal_ula;
   assign bus.origem_ula_a        = origem_ula_a;
   assign bus.origem_ula_b        = origem_ula_b;
   assign bus.origem_pc           = origem_pc;
   assign bus.iord                = iord;
   assign bus.le_mem              = le_mem;
   assign bus.escreve_mem         = escreve_mem;
   assign bus.escreve_ir          = escreve_ir;
   assign bus.escreve_pc          = escreve_pc;
   assign bus.escreve_end         = escreve_end;
   assign bus.escreve_reg         = escreve_reg;
   assign bus.mem_para_reg        = mem_para_reg;
   assign bus.parado              = parado;
   assign bus.erro                = erro_q;
   assign bus.contador_instrucoes = cont_q;

endmodule
